// File: rtl/spi_slave_frame_rx.sv
// SPI slave frame receiver: oversamples SCLK/CS_N/SDI in the CLK domain and delivers one CS_N-framed word over valid/ready.
// Optional odd-parity trailer bit enabled by defining SPI_FRAME_PARITY_EN.
module spi_slave_frame_rx #(
    parameter int DATA_W      = 16,
    parameter int FIELD_A_W   = 8,
    parameter bit LSB_FIRST   = 1'b1,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        CS_N,
    input  logic                        SCLK,
    input  logic                        SDI,
    output logic [DATA_W-1:0]           frame_data,
    output logic [FIELD_A_W-1:0]        field_a,
    output logic [DATA_W-FIELD_A_W-1:0] field_b,
    output logic                        frame_valid,
    input  logic                        frame_ready,
    output logic                        frame_err,
    output logic                        overrun,
    output logic                        busy
);

`ifdef SPI_FRAME_PARITY_EN
    localparam int FRAME_BITS = DATA_W + 1;
`else
    localparam int FRAME_BITS = DATA_W;
`endif
    localparam int CNT_W  = $clog2(FRAME_BITS + 1);
    localparam int FILL_W = $clog2(SYNC_STAGES + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SHIFT   = 2'd1;
    localparam logic [1:0] ST_WAIT_CS = 2'd2;

    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_sdi_sync;
    logic [FILL_W-1:0]      r_fill_cnt;
    logic                   r_armed;
    logic [1:0]             r_state;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [DATA_W-1:0]      r_shift;
    logic                   r_long;
`ifdef SPI_FRAME_PARITY_EN
    logic                   r_parity;
`endif

    logic              w_cs_new, w_cs_old, w_cs_fall, w_cs_rise;
    logic              w_sclk_rise, w_sclk_fall, w_sample, w_sdi;
    logic              w_fill_done, w_last_bit, w_good;
    logic [DATA_W-1:0] w_shift_next;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cs_sync   <= '1;
            r_sclk_sync <= {SYNC_STAGES{CPOL}};
            r_sdi_sync  <= '0;
        end else begin
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], CS_N};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
            r_sdi_sync  <= {r_sdi_sync[SYNC_STAGES-2:0], SDI};
        end
    end

    assign w_cs_new    = r_cs_sync[SYNC_STAGES-2];
    assign w_cs_old    = r_cs_sync[SYNC_STAGES-1];
    assign w_cs_fall   = w_cs_old & ~w_cs_new;
    assign w_cs_rise   = ~w_cs_old & w_cs_new;
    assign w_sclk_rise = ~r_sclk_sync[SYNC_STAGES-1] & r_sclk_sync[SYNC_STAGES-2];
    assign w_sclk_fall = r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_sync[SYNC_STAGES-2];
    assign w_sample    = ((CPOL == CPHA) ? w_sclk_rise : w_sclk_fall) & ~w_cs_new;
    assign w_sdi       = r_sdi_sync[SYNC_STAGES-1];

    // Only accept a CS_N fall once the synchroniser holds real samples showing CS_N high,
    // so a chip select already low when reset releases cannot start a frame.
    assign w_fill_done = (r_fill_cnt == FILL_W'(SYNC_STAGES - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_fill_cnt <= '0;
            r_armed    <= 1'b0;
        end else begin
            if (!w_fill_done) r_fill_cnt <= r_fill_cnt + FILL_W'(1);
            if (w_fill_done && w_cs_new) r_armed <= 1'b1;
        end
    end

    assign w_shift_next = LSB_FIRST ? {w_sdi, r_shift[DATA_W-1:1]} : {r_shift[DATA_W-2:0], w_sdi};
    assign w_last_bit   = (r_bit_cnt == CNT_W'(FRAME_BITS - 1));
`ifdef SPI_FRAME_PARITY_EN
    assign w_good = ~r_long & (^r_shift ^ r_parity);
`else
    assign w_good = ~r_long;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_long      <= 1'b0;
`ifdef SPI_FRAME_PARITY_EN
            r_parity    <= 1'b0;
`endif
            frame_data  <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (frame_valid && frame_ready) frame_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_armed && w_cs_fall) begin
                        r_state   <= ST_SHIFT;
                        r_bit_cnt <= '0;
                        r_shift   <= '0;
                        r_long    <= 1'b0;
`ifdef SPI_FRAME_PARITY_EN
                        r_parity  <= 1'b0;
`endif
                    end
                end
                ST_SHIFT: begin
                    if (w_cs_rise) begin
                        frame_err <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else if (w_sample) begin
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
`ifdef SPI_FRAME_PARITY_EN
                        if (r_bit_cnt == CNT_W'(DATA_W)) r_parity <= w_sdi;
                        else r_shift <= w_shift_next;
`else
                        r_shift <= w_shift_next;
`endif
                        if (w_last_bit) r_state <= ST_WAIT_CS;
                    end
                end
                ST_WAIT_CS: begin
                    // A commit coinciding with an accept of the old word simply replaces it.
                    if (w_cs_rise) begin
                        r_state <= ST_IDLE;
                        if (!w_good) begin
                            frame_err <= 1'b1;
                        end else if (frame_valid && !frame_ready) begin
                            overrun <= 1'b1;
                        end else begin
                            frame_data  <= r_shift;
                            frame_valid <= 1'b1;
                        end
                    end else if (w_sample) begin
                        r_long <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy    = (r_state != ST_IDLE);
    assign field_a = frame_data[DATA_W-1 -: FIELD_A_W];
    assign field_b = frame_data[DATA_W-FIELD_A_W-1:0];

endmodule

// File: tb/tb_spi_slave_frame_rx.sv
// Scoreboard bench for spi_slave_frame_rx: four instances covering SPI modes 0-3, checked against a frame-level model.
// Parity cases are exercised when SPI_FRAME_PARITY_EN is defined.
module tb_spi_slave_frame_rx;

    localparam int NI   = 4;
    localparam int SYNC = 2;
    localparam int HALF = 4;
`ifdef SPI_FRAME_PARITY_EN
    localparam int FB = 17;
`else
    localparam int FB = 16;
`endif
    localparam logic [1:0] EV_DATA = 2'd0;
    localparam logic [1:0] EV_ERR  = 2'd1;
    localparam logic [1:0] EV_OVR  = 2'd2;

    typedef struct packed {
        logic [1:0]  inst;
        logic [1:0]  kind;
        logic [15:0] data;
    } ev_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        frameReady = 1'b1;
    logic        csn[NI], sclk[NI], sdi[NI];
    logic [15:0] fdata[NI];
    logic [7:0]  fa[NI], fb[NI];
    logic        fvalid[NI], ferr[NI], ovr[NI], busyS[NI];
    logic        held[NI];
    logic        prevValid[NI], prevAcc[NI];
    ev_t         expQ[$];
    int          tests = 0;
    int          fails = 0;

    always #5 CLK = ~CLK;

    // Instance k runs SPI mode k; only mode 0 is LSB first.
    for (genvar g = 0; g < NI; g++) begin : gDut
        spi_slave_frame_rx #(
            .DATA_W(16), .FIELD_A_W(8), .LSB_FIRST(g == 0),
            .CPOL((g / 2) == 1), .CPHA((g % 2) == 1), .SYNC_STAGES(SYNC)
        ) dut (
            .CLK(CLK), .RST(RST), .CS_N(csn[g]), .SCLK(sclk[g]), .SDI(sdi[g]),
            .frame_data(fdata[g]), .field_a(fa[g]), .field_b(fb[g]),
            .frame_valid(fvalid[g]), .frame_ready(frameReady),
            .frame_err(ferr[g]), .overrun(ovr[g]), .busy(busyS[g])
        );
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Every DUT event (error pulse, overrun pulse, newly presented word) consumes one expectation.
    task automatic handleEvent(input int k, input logic [1:0] kind, input logic [15:0] d,
                               input logic [7:0] a, input logic [7:0] b);
        ev_t e;
        tests++;
        if (expQ.size() == 0) begin
            fails++;
            $display("[TB] FAIL unexpected_event: inst %0d kind %0d data 0x%0h, none expected", k, kind, d);
        end else begin
            e = expQ.pop_front();
            if (e.inst != 2'(k) || e.kind != kind || e.data != d) begin
                fails++;
                $display("[TB] FAIL event: got inst %0d kind %0d data 0x%0h, expected inst %0d kind %0d data 0x%0h",
                         k, kind, d, e.inst, e.kind, e.data);
            end
            if (e.kind == EV_DATA && kind == EV_DATA) begin
                checkOutput("field_a", 32'(a), 32'(e.data[15:8]));
                checkOutput("field_b", 32'(b), 32'(e.data[7:0]));
            end
        end
    endtask

    always @(negedge CLK) begin
        for (int k = 0; k < NI; k++) begin
            if (RST) begin
                prevValid[k] = 1'b0;
                prevAcc[k]   = 1'b0;
            end else begin
                if (ferr[k]) handleEvent(k, EV_ERR, 16'h0, 8'h0, 8'h0);
                if (ovr[k])  handleEvent(k, EV_OVR, 16'h0, 8'h0, 8'h0);
                if (fvalid[k] && (!prevValid[k] || prevAcc[k]))
                    handleEvent(k, EV_DATA, fdata[k], fa[k], fb[k]);
                prevValid[k] = fvalid[k];
                prevAcc[k]   = fvalid[k] && frameReady;
            end
        end
    end

    task automatic waitCyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic setReady(input logic v);
        frameReady = v;
        if (v) for (int k = 0; k < NI; k++) held[k] = 1'b0;
    endtask

    // Bit i of the result is the i-th bit on the wire; positions past the frame are random filler.
    function automatic logic [63:0] buildStream(input int k, input logic [15:0] w, input bit badPar);
        logic [63:0] s;
        s = {$urandom, $urandom};
        for (int i = 0; i < 16; i++) s[i] = (k == 0) ? w[i] : w[15 - i];
`ifdef SPI_FRAME_PARITY_EN
        s[16] = ~(^w) ^ badPar;
`else
        if (badPar) s[16] = s[16];
`endif
        return s;
    endfunction

    task automatic sendBits(input int k, input logic [63:0] stream, input int n, input bit raise);
        logic cpol, cpha;
        cpol = ((k / 2) == 1);
        cpha = ((k % 2) == 1);
        csn[k] = 1'b0;
        waitCyc(HALF);
        for (int i = 0; i < n; i++) begin
            if (!cpha) begin
                sdi[k] = stream[i];
                waitCyc(HALF);
                sclk[k] = ~cpol;
                waitCyc(HALF);
                sclk[k] = cpol;
            end else begin
                sclk[k] = ~cpol;
                sdi[k] = stream[i];
                waitCyc(HALF);
                sclk[k] = cpol;
                waitCyc(HALF);
            end
        end
        waitCyc(HALF);
        if (raise) csn[k] = 1'b1;
    endtask

    task automatic drain();
        for (int c = 0; c < 60 && expQ.size() != 0; c++) waitCyc(1);
        tests++;
        if (expQ.size() != 0) begin
            fails++;
            $display("[TB] FAIL drain_timeout: %0d events outstanding, expected 0", expQ.size());
            expQ.delete();
        end
        waitCyc(4);
    endtask

    // Frame-level reference: a frame is good only with exactly FB bits and correct parity;
    // a good frame overruns if the instance still holds an unaccepted word.
    task automatic applyStimulus(input int k, input logic [15:0] w, input int n, input bit badPar);
        ev_t e;
        e.inst = 2'(k);
        e.data = 16'h0;
        if (n == FB && !badPar) begin
            if (held[k]) begin
                e.kind = EV_OVR;
            end else begin
                e.kind = EV_DATA;
                e.data = w;
                if (!frameReady) held[k] = 1'b1;
            end
        end else begin
            e.kind = EV_ERR;
        end
        expQ.push_back(e);
        sendBits(k, buildStream(k, w, badPar), n, 1'b1);
        drain();
    endtask

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        ev_t e;
        int  lat, sel, nb;
        logic [15:0] w;
        for (int k = 0; k < NI; k++) begin
            csn[k]  = 1'b1;
            sclk[k] = ((k / 2) == 1);
            sdi[k]  = 1'b0;
            held[k] = 1'b0;
        end
        waitCyc(3);
        checkOutput("reset_frame_data", 32'(fdata[0]), 32'h0);
        checkOutput("reset_valid", 32'(fvalid[0]), 32'h0);
        checkOutput("reset_err", 32'(ferr[0]), 32'h0);
        checkOutput("reset_overrun", 32'(ovr[0]), 32'h0);
        checkOutput("reset_busy", 32'(busyS[3]), 32'h0);
        RST = 1'b0;
        waitCyc(6);

        // Mode 0 LSB first with latency and handshake timing
        e = '{inst: 2'd0, kind: EV_DATA, data: 16'hA53C};
        expQ.push_back(e);
        sendBits(0, buildStream(0, 16'hA53C, 1'b0), FB, 1'b0);
        csn[0] = 1'b1;
        lat = 0;
        while (!fvalid[0] && lat < SYNC + 4) begin
            waitCyc(1);
            lat++;
        end
        checkOutput("valid_latency_ok", 32'(lat <= SYNC + 1), 32'h1);
        checkOutput("mode0_data", 32'(fdata[0]), 32'hA53C);
        checkOutput("mode0_field_a", 32'(fa[0]), 32'hA5);
        checkOutput("mode0_field_b", 32'(fb[0]), 32'h3C);
        waitCyc(1);
        checkOutput("valid_clears", 32'(fvalid[0]), 32'h0);
        drain();

        for (int k = 1; k < NI; k++) applyStimulus(k, 16'h1234, FB, 1'b0);

        applyStimulus(0, 16'hBEEF, 9, 1'b0);
        applyStimulus(0, 16'hBEEF, FB + 1, 1'b0);
        applyStimulus(2, 16'hC0DE, 9, 1'b0);

        setReady(1'b0);
        applyStimulus(0, 16'h1111, FB, 1'b0);
        applyStimulus(0, 16'h2222, FB, 1'b0);
        checkOutput("overrun_keeps_old", 32'(fdata[0]), 32'h1111);
        setReady(1'b1);
        waitCyc(3);
        setReady(1'b0);
        applyStimulus(0, 16'h3333, FB, 1'b0);
        e = '{inst: 2'd0, kind: EV_DATA, data: 16'h2222};
        expQ.push_back(e);
        sendBits(0, buildStream(0, 16'h2222, 1'b0), FB, 1'b0);
        csn[0] = 1'b1;
        waitCyc(SYNC - 1);
        setReady(1'b1);
        drain();
        checkOutput("same_cycle_data", 32'(fdata[0]), 32'h2222);

        // Reset mid-frame, released with CS_N still low
        sendBits(0, buildStream(0, 16'hDEAD, 1'b0), 8, 1'b0);
        checkOutput("busy_mid_frame", 32'(busyS[0]), 32'h1);
        RST = 1'b1;
        waitCyc(3);
        RST = 1'b0;
        waitCyc(6);
        csn[0] = 1'b1;
        waitCyc(6);
        applyStimulus(0, 16'h00FF, FB, 1'b0);

        for (int i = 0; i < 6; i++) begin
            sclk[0] = ~sclk[0];
            waitCyc(HALF);
        end
        drain();
        applyStimulus(0, 16'h5A5A, FB, 1'b0);

`ifdef SPI_FRAME_PARITY_EN
        applyStimulus(0, 16'h0001, FB, 1'b0);
        applyStimulus(0, 16'h0001, FB, 1'b1);
`endif

        for (int it = 0; it < 14; it++) begin
            setReady($urandom_range(0, 3) != 0);
            sel = $urandom_range(0, 5);
            w   = 16'($urandom);
            nb  = FB;
            if (sel == 0) nb = $urandom_range(1, FB - 1);
            if (sel == 1) nb = FB + $urandom_range(1, 2);
`ifdef SPI_FRAME_PARITY_EN
            applyStimulus($urandom_range(0, NI - 1), w, nb, sel == 2);
`else
            applyStimulus($urandom_range(0, NI - 1), w, nb, 1'b0);
`endif
        end
        setReady(1'b1);
        waitCyc(10);
        checkOutput("queue_empty", 32'(expQ.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_slave_frame_rx.md
Name: spi_slave_frame_rx

Overview:
- Parametrised SPI slave receiver. Runs in the system clock domain and oversamples SCLK, CS_N and SDI.
- Assembles one CS_N-framed word of DATA_W bits and splits it into two fields: field_a (upper FIELD_A_W bits, e.g. length) and field_b (remaining lower bits, e.g. width).
- Delivers the word over a valid/ready handshake to the downstream config logic.
- Supports all four SPI modes and selectable bit order, and flags short, long and overrun frames.

Parameters:
- DATA_W, 16, frame payload width in bits (4..64).
- FIELD_A_W, 8, width of field_a, taken from frame_data[DATA_W-1 -: FIELD_A_W]; field_b = frame_data[DATA_W-FIELD_A_W-1:0].
- LSB_FIRST, 1, 1 = first received bit goes to bit 0; 0 = first bit goes to bit DATA_W-1.
- CPOL, 0, SCLK idle level.
- CPHA, 0, SPI clock phase.
- SYNC_STAGES, 2, synchroniser depth for SCLK, CS_N and SDI (>=2).

Ports:
- CLK  in  1  system clock; must be >= 4x SCLK frequency.
- RST  in  1  asynchronous, active-high reset.
- CS_N  in  1  SPI chip select, active low, asynchronous to CLK.
- SCLK  in  1  SPI clock, asynchronous to CLK.
- SDI  in  1  SPI data in.
- frame_data  out  DATA_W  last accepted frame.
- field_a  out  FIELD_A_W  upper field of frame_data.
- field_b  out  DATA_W-FIELD_A_W  lower field of frame_data.
- frame_valid  out  1  frame available; held until accepted.
- frame_ready  in  1  downstream accept.
- frame_err  out  1  one-cycle pulse: short, long or parity-bad frame discarded.
- overrun  out  1  one-cycle pulse: good frame dropped because output still held.
- busy  out  1  high while in SHIFT or WAIT_CS.

Behaviour:
- Reset values: frame_data=0, frame_valid=0, frame_err=0, overrun=0, busy=0, bit counter=0, state=IDLE, synchroniser flops load idle values (CS_N=1, SCLK=CPOL).
- Synchronisation: SCLK, CS_N and SDI each pass through SYNC_STAGES flops. Edges are detected from the last two stages.
- Sample edge: rising SCLK when CPOL==CPHA, otherwise falling. SDI is sampled from the synchronised stage in the same cycle the edge is detected.
- State IDLE -> SHIFT on a CS_N falling edge, clearing the shift register and counter. A CS_N already low when RST releases is ignored until CS_N goes high and then falls again.
- State SHIFT: each sample edge shifts one bit in (position per LSB_FIRST) and increments the counter. When the counter reaches FRAME_BITS (DATA_W, plus 1 with parity) -> WAIT_CS.
- State SHIFT, CS_N rise before FRAME_BITS reached: frame_err pulses, frame discarded -> IDLE.
- State WAIT_CS: any further sample edge marks the frame long. On CS_N rise:
  - long or parity-bad frame -> frame_err pulses, frame discarded.
  - otherwise the word is committed to the output.
  - -> IDLE in both cases.
- Commit: frame_data loads and frame_valid=1 in the cycle after the synchronised CS_N rise is detected. Pin-to-valid latency = SYNC_STAGES+1 CLK.
- Handshake:
  - frame_valid falls in the cycle after frame_valid&&frame_ready; frame_data stays stable while valid.
  - Commit while valid&&!ready: overrun pulses, new word dropped, old word retained.
  - Commit in the same cycle as valid&&ready: new word loads, frame_valid stays 1, no overrun.
- frame_err and overrun are mutually exclusive per frame. Each is exactly one CLK wide.
- SCLK edges while CS_N is high are ignored.
- RST mid-frame aborts the frame with no error pulse.

Optional Feature:
- Macro SPI_FRAME_PARITY_EN.
- Defined: one extra odd-parity bit follows the DATA_W payload and FRAME_BITS=DATA_W+1. The frame is good only if the XOR of payload and parity bit = 1; otherwise frame_err pulses on CS_N rise.
- Undefined: FRAME_BITS=DATA_W and there is no parity logic.

Test Plan:
- Mode 0, LSB_FIRST=1, send 16 bits of 0xA53C LSB first, raise CS_N -> frame_valid within SYNC_STAGES+1 CLK, frame_data=0xA53C, field_a=0xA5, field_b=0x3C; frame_ready=1 clears valid next cycle.
- Modes 1/2/3 and LSB_FIRST=0, send 0x1234 MSB first -> frame_data=0x1234 in every mode.
- CS_N rise after 9 bits -> frame_err single pulse, frame_valid stays 0; send 17 bits -> frame_err, no valid.
- Frame 0x1111 accepted with frame_ready=0, then frame 0x2222 -> overrun pulse, frame_data stays 0x1111; repeat with frame_ready=1 in the commit cycle -> frame_data=0x2222, no overrun.
- Assert RST after 8 bits, release, send a full 0x00FF frame -> only 0x00FF delivered, no error pulse.
- SPI_FRAME_PARITY_EN: 0x0001 with parity bit 0 -> valid; with parity bit 1 -> frame_err, no valid.
